chacha20_stream_xor: RTL



---
 rtl/chacha20_pkg.sv | 29 ++
 rtl/chacha20_stream_xor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/chacha20_pkg.sv
// Shared definitions for the ChaCha20 keystream datapath: FSM states, block sizing,
// keystream word access and the RFC 8439 constants also used by the block core.
package chacha20_pkg;

    localparam int CTR_W_DEF     = 32;
    localparam int WORDS_PER_BLK = 16;
    localparam int IDX_W         = $clog2(WORDS_PER_BLK);
    localparam int KS_W          = 32 * WORDS_PER_BLK;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

    // "expand 32-byte k"
    localparam logic [31:0] CHACHA_C0 = 32'h61707865;
    localparam logic [31:0] CHACHA_C1 = 32'h3320646e;
    localparam logic [31:0] CHACHA_C2 = 32'h79622d32;
    localparam logic [31:0] CHACHA_C3 = 32'h6b206574;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    function automatic logic [31:0] ks_word(input logic [KS_W-1:0] blk, input logic [IDX_W-1:0] idx);
        return blk[{idx, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/chacha20_stream_xor.sv
// Requests keystream blocks from the ChaCha20 core and XORs them onto a 32-bit valid/ready stream.
// Build option CHACHA20_PREFETCH_EN adds a second buffer that fetches the next block while streaming.
module chacha20_stream_xor
    import chacha20_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CTR_W-1:0] cfg_ctr_init,
    output logic             blk_start,
    output logic [CTR_W-1:0] blk_counter,
    input  logic [KS_W-1:0]  blk_keystream,
    input  logic             blk_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err_ctr_wrap
);

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    state_t              state_r;
    logic [CTR_W-1:0]    ctr_r;
    logic [IDX_W-1:0]    idx_r;
    logic [KS_W-1:0]     ks_buf_r;
    logic                ctr_last_s;
    logic                stall_s;
    logic                in_ready_s;
    logic                accept_s;
`ifdef CHACHA20_PREFETCH_EN
    logic [KS_W-1:0]     ks_next_r;
    logic                pf_valid_r;  // ks_next_r holds the block for ctr_r+1
    logic                pf_busy_r;   // a prefetch request is outstanding at the core
    logic                pf_live_r;   // and its result is still wanted
`endif

    assign ctr_last_s = (ctr_r == CTR_MAX);

`ifdef CHACHA20_PREFETCH_EN
    assign stall_s = (idx_r == LAST_IDX) && !pf_valid_r && !ctr_last_s;
`else
    assign stall_s = 1'b0;
`endif

    // Input handshake: accept only while streaming and the output register can take a word
    always_comb begin
        if ((state_r == ST_STREAM) && !stall_s) begin
            in_ready_s = ~out_valid | out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign in_ready = in_ready_s;
    assign accept_s = in_valid & in_ready_s;

    // FSM, keystream buffers and the registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ctr_r        <= '0;
            idx_r        <= '0;
            ks_buf_r     <= '0;
            blk_start    <= 1'b0;
            blk_counter  <= '0;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            err_ctr_wrap <= 1'b0;
`ifdef CHACHA20_PREFETCH_EN
            ks_next_r    <= '0;
            pf_valid_r   <= 1'b0;
            pf_busy_r    <= 1'b0;
            pf_live_r    <= 1'b0;
`endif
        end else begin
            blk_start <= 1'b0;

            if (accept_s) begin
                out_data  <= in_data ^ ks_word(ks_buf_r, idx_r);
                out_last  <= in_last;
                out_valid <= 1'b1;
                idx_r     <= idx_r + IDX_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

`ifdef CHACHA20_PREFETCH_EN
            if (blk_done && pf_busy_r) begin
                pf_busy_r <= 1'b0;
                pf_live_r <= 1'b0;
                if (pf_live_r) begin
                    ks_next_r  <= blk_keystream;
                    pf_valid_r <= 1'b1;
                end
            end
`endif

            case (state_r)
                ST_IDLE, ST_ERR: begin
                    if (cfg_start) begin
                        ctr_r        <= cfg_ctr_init;
                        busy         <= 1'b1;
                        err_ctr_wrap <= 1'b0;
                        state_r      <= ST_REQ;
                    end
                end
                ST_REQ: begin
`ifdef CHACHA20_PREFETCH_EN
                    // A prefetch flushed by in_last may still be running; let the core finish it first
                    if (!pf_busy_r) begin
                        blk_start   <= 1'b1;
                        blk_counter <= ctr_r;
                        state_r     <= ST_WAIT;
                    end
`else
                    blk_start   <= 1'b1;
                    blk_counter <= ctr_r;
                    state_r     <= ST_WAIT;
`endif
                end
                ST_WAIT: begin
                    if (blk_done) begin
                        ks_buf_r <= blk_keystream;
                        idx_r    <= '0;
                        state_r  <= ST_STREAM;
`ifdef CHACHA20_PREFETCH_EN
                        if (!ctr_last_s) begin
                            blk_start   <= 1'b1;
                            blk_counter <= ctr_r + CTR_W'(1);
                            pf_busy_r   <= 1'b1;
                            pf_live_r   <= 1'b1;
                        end
`endif
                    end
                end
                ST_STREAM: begin
                    if (accept_s) begin
                        if (in_last) begin
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
`ifdef CHACHA20_PREFETCH_EN
                            pf_valid_r <= 1'b0;
                            pf_live_r  <= 1'b0;
`endif
                        end else if (idx_r == LAST_IDX) begin
                            if (ctr_last_s) begin
                                err_ctr_wrap <= 1'b1;
                                state_r      <= ST_ERR;
                            end else begin
                                ctr_r <= ctr_r + CTR_W'(1);
`ifdef CHACHA20_PREFETCH_EN
                                ks_buf_r   <= ks_next_r;
                                pf_valid_r <= 1'b0;
                                if ((ctr_r + CTR_W'(1)) != CTR_MAX) begin
                                    blk_start   <= 1'b1;
                                    blk_counter <= ctr_r + CTR_W'(2);
                                    pf_busy_r   <= 1'b1;
                                    pf_live_r   <= 1'b1;
                                end
`else
                                state_r <= ST_REQ;
`endif
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
